// File: rtl/cpu_types_pkg.sv
// Shared CPU types: multiply/divide op and state encodings, decoded-instruction
// fields, plus small op-decode helpers for the multiply/divide sequencer.
//
// Request/response handshake used by muldiv_sequencer: a transfer happens on a
// rising edge where valid && ready are both high. A producer holds its payload
// stable while valid is high and ready is low. Ready may depend on valid, but
// valid never depends on ready.
package cpu_types;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } muldiv_state_t;

  // Execute-stage status; ready is held low while a mul/div is outstanding.
  typedef struct packed {
    logic ready;
    logic stall;
  } stage_status_t;

  // Decoded instruction fields relevant to the execute stage.
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    muldiv_op_t md_op;
    logic       is_muldiv;
    logic       is_load;
    logic       is_store;
    logic       is_branch;
  } decoded_instr_t;

  // Divide-class ops (DIV/DIVU/REM/REMU) share the top encoding bit.
  function automatic logic md_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

  // REM/REMU return the remainder rather than the quotient.
  function automatic logic md_is_rem(input muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  // rs1 is interpreted as signed for MUL/MULH/MULHSU/DIV/REM.
  function automatic logic md_signed_a(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
           (op == MD_DIV) || (op == MD_REM);
  endfunction

  // rs2 is interpreted as signed for MUL/MULH/DIV/REM.
  function automatic logic md_signed_b(input muldiv_op_t op);
    return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit. One operation in flight; a single
// shift-add / restoring-divide datapath is stepped one bit per cycle.
// Optional build macro: MULDIV_EARLY_OUT_EN lets multiplies leave CALC as soon
// as the remaining multiplier bits are all zero.
module muldiv_sequencer
  import cpu_types::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  muldiv_op_t           req_op,
  input  logic [WIDTH-1:0]     req_a,
  input  logic [WIDTH-1:0]     req_b,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 busy,
  output muldiv_state_t        dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_t          state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  muldiv_op_t             op_q, op_d;
  logic                   sa_q, sa_d;
  logic                   sb_q, sb_d;
  // Mul: running 2W product. Div: {remainder, dividend/quotient shift}.
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  // Mul: multiplicand shifted left each step. Div: divisor in the low half.
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  // Mul: multiplier shifted right each step (unused by divide).
  logic [WIDTH-1:0]       mlt_q, mlt_d;
  logic [WIDTH-1:0]       res_q, res_d;

  // Accept-side decode: sign flags, magnitudes and special cases.
  logic                   in_sa, in_sb, in_div, in_rem;
  logic                   in_bzero, in_ovf;
  logic [WIDTH-1:0]       mag_a, mag_b, special_res;

  always_comb begin
    in_div      = md_is_div(req_op);
    in_rem      = md_is_rem(req_op);
    in_sa       = md_signed_a(req_op) & req_a[WIDTH-1];
    in_sb       = md_signed_b(req_op) & req_b[WIDTH-1];
    mag_a       = in_sa ? (~req_a + 1'b1) : req_a;
    mag_b       = in_sb ? (~req_b + 1'b1) : req_b;
    in_bzero    = in_div && (req_b == '0);
    in_ovf      = ((req_op == MD_DIV) || (req_op == MD_REM)) &&
                  (req_a == MIN_NEG) && (req_b == '1);
    special_res = '0;
    if (in_bzero) begin
      special_res = in_rem ? req_a : '1;
    end else if (in_ovf) begin
      special_res = in_rem ? '0 : req_a;
    end
  end

  // One datapath step plus the signed result that step would produce.
  logic [WIDTH:0]         rem_sh, rem_diff;
  logic                   qbit;
  logic [2*WIDTH-1:0]     acc_step, prod_s;
  logic [WIDTH-1:0]       quo_u, rem_u, fin_res;
  logic                   calc_last;

  always_comb begin
    rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    rem_diff = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
    qbit     = ~rem_diff[WIDTH];
    if (md_is_div(op_q)) begin
      acc_step = qbit ? {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                      : {acc_q[2*WIDTH-2:0], 1'b0};
    end else begin
      acc_step = mlt_q[0] ? (acc_q + mcand_q) : acc_q;
    end
    prod_s = (sa_q ^ sb_q) ? (~acc_step + 1'b1) : acc_step;
    quo_u  = acc_step[WIDTH-1:0];
    rem_u  = acc_step[2*WIDTH-1:WIDTH];
    if (md_is_div(op_q)) begin
      if (md_is_rem(op_q)) begin
        fin_res = sa_q ? (~rem_u + 1'b1) : rem_u;
      end else begin
        fin_res = (sa_q ^ sb_q) ? (~quo_u + 1'b1) : quo_u;
      end
    end else begin
      fin_res = (op_q == MD_MUL) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
    end
`ifdef MULDIV_EARLY_OUT_EN
    calc_last = (cnt_q == '0) ||
                (!md_is_div(op_q) && (mlt_q[WIDTH-1:1] == '0));
`else
    calc_last = (cnt_q == '0);
`endif
  end

  // Next-state and datapath register updates; flush overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mlt_d   = mlt_q;
    res_d   = res_q;
    case (state_q)
      MD_IDLE: begin
        if (req_valid && req_ready) begin
          op_d = req_op;
          sa_d = in_sa;
          sb_d = in_sb;
          if (in_bzero || in_ovf) begin
            res_d   = special_res;
            state_d = MD_DONE;
          end else begin
            cnt_d   = CW'(WIDTH - 1);
            state_d = MD_CALC;
            if (in_div) begin
              acc_d   = {{WIDTH{1'b0}}, mag_a};
              mcand_d = {{WIDTH{1'b0}}, mag_b};
              mlt_d   = '0;
            end else begin
              acc_d   = '0;
              mcand_d = {{WIDTH{1'b0}}, mag_a};
              mlt_d   = mag_b;
            end
          end
        end
      end
      MD_CALC: begin
        acc_d = acc_step;
        if (!md_is_div(op_q)) begin
          mcand_d = mcand_q << 1;
          mlt_d   = mlt_q >> 1;
        end
        if (calc_last) begin
          res_d   = fin_res;
          cnt_d   = '0;
          state_d = MD_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      MD_DONE: begin
        if (resp_ready) begin
          state_d = MD_IDLE;
        end
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush) begin
      state_d = MD_IDLE;
      cnt_d   = '0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      acc_q   <= '0;
      mcand_q <= '0;
      mlt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mlt_q   <= mlt_d;
      res_q   <= res_d;
    end
  end

  // Port outputs; data is forced to zero whenever no result is presented.
  always_comb begin
    busy       = (state_q != MD_IDLE);
    resp_valid = (state_q == MD_DONE);
    resp_data  = resp_valid ? res_q : '0;
    req_ready  = rst_n && (state_q == MD_IDLE) && !flush;
    dbg_state  = state_q;
  end

endmodule
